// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width and the Gray-code helpers
// used by both the write and read control blocks.
package fifo_pkg;

   localparam int FIFO_ADDRESSSIZE = 4;

   // Work on a 32-bit container so any pointer width fits after zero-extension.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ {1'b0, bin[31:1]};
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low reset; both stages are
// exposed because the full flag looks one stage ahead.
module sync_2ff #(
   parameter int width = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] d,
   output logic [width-1:0] stage1,
   output logic [width-1:0] q
);

   // Synchronizer flop chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage1 <= '0;
         q      <= '0;
      end else begin
         stage1 <= d;
         q      <= stage1;
      end
   end

endmodule

// File: rtl/write_control.sv
// Write-side pointer and flag logic of a dual-clock FIFO.
// Define WCTRL_ALMOST_FULL_EN to build the almost-full comparator.
module write_control
   import fifo_pkg::*;
#(
   parameter int addresssize = FIFO_ADDRESSSIZE,
   parameter int af_level    = 12
) (
   input  logic                 wclk,
   input  logic                 wrst_n,
   input  logic                 wen,
   input  logic [addresssize:0] rptr_gray,
   output logic [addresssize-1:0] waddr,
   output logic [addresssize:0] wptr_gray,
   output logic                 wfull,
   output logic                 walmost_full,
   output logic                 woverflow,
   output logic [addresssize:0] wcount
);

   typedef logic [addresssize:0] ptr_t;

   ptr_t wbin;
   ptr_t wbin_next;
   ptr_t wgray_next;
   ptr_t rsync1;
   ptr_t rsync2;
   ptr_t rbin_sync;
   ptr_t full_pattern;
   logic write_ok;
   logic wfull_next;

   if ((af_level < 1) || (af_level > (32'sd1 << addresssize))) begin : g_bad_af_level
      $error("write_control: af_level outside 1..2**addresssize");
   end

   sync_2ff #(.width(addresssize + 1)) u_rsync (
      .clk    (wclk),
      .rst_n  (wrst_n),
      .d      (rptr_gray),
      .stage1 (rsync1),
      .q      (rsync2)
   );

   // Next pointer and full detection; rsync1 is what rsync2 will hold after this
   // edge, so the registered flag stays consistent with wcount.
   always_comb begin
      write_ok     = wen & ~wfull;
      wbin_next    = wbin + ptr_t'(write_ok);
      wgray_next   = ptr_t'(bin2gray(32'(wbin_next)));
      full_pattern = {~rsync1[addresssize:addresssize-1], rsync1[addresssize-2:0]};
      wfull_next   = (wgray_next == full_pattern);
   end

   // Pointer, flag and sticky overflow registers
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin      <= '0;
         wptr_gray <= '0;
         wfull     <= 1'b0;
         woverflow <= 1'b0;
      end else begin
         wbin      <= wbin_next;
         wptr_gray <= wgray_next;
         wfull     <= wfull_next;
         woverflow <= woverflow | (wen & wfull);
      end
   end

   // Fill level seen from the write domain
   always_comb begin
      rbin_sync = ptr_t'(gray2bin(32'(rsync2)));
      wcount    = wbin - rbin_sync;
      waddr     = wbin[addresssize-1:0];
   end

`ifdef WCTRL_ALMOST_FULL_EN
   localparam ptr_t AF_THRESHOLD = ptr_t'(af_level);

   // Almost-full comparator
   always_comb begin
      walmost_full = (wcount >= AF_THRESHOLD);
   end
`else
   assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_write_control.sv
// Directed self-checking bench for write_control (addresssize=4, af_level=12).
// Honours WCTRL_ALMOST_FULL_EN when computing almost-full expectations.
module tb_write_control;

`ifdef WCTRL_ALMOST_FULL_EN
   localparam bit AF_EN = 1'b1;
`else
   localparam bit AF_EN = 1'b0;
`endif

   logic       wclk = 1'b0;
   logic       wrst_n = 1'b1;
   logic       wen = 1'b0;
   logic [4:0] rptr_gray = 5'b0;
   logic [3:0] waddr;
   logic [4:0] wptr_gray;
   logic       wfull;
   logic       walmost_full;
   logic       woverflow;
   logic [4:0] wcount;

   int tests_run = 0;
   int tests_failed = 0;

   write_control #(.addresssize(4), .af_level(12)) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .wen          (wen),
      .rptr_gray    (rptr_gray),
      .waddr        (waddr),
      .wptr_gray    (wptr_gray),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .woverflow    (woverflow),
      .wcount       (wcount)
   );

   always #5 wclk = ~wclk;

   function automatic logic [4:0] g5(input int v);
      logic [4:0] b;
      b = 5'(v);
      return b ^ (b >> 1);
   endfunction

   task automatic step();
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      step();
      wen = 1'b0;
      rptr_gray = 5'b0;
      wrst_n = 1'b0;
      #2;
      wrst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 wrst_n = 1'b0;
      #2;
      tests_run++;
      if ({waddr, wptr_gray, wfull, walmost_full, woverflow, wcount} !== 17'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs got %b expected all zero",
                  {waddr, wptr_gray, wfull, walmost_full, woverflow, wcount});
      end
      #3 wrst_n = 1'b1;
   endtask

   task automatic test_fill_full();
      do_reset();
      wen = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         tests_run++;
         if ({wfull, wcount, waddr, walmost_full} !== {(k == 16), 5'(k), 4'(k), (AF_EN && k >= 12)}) begin
            tests_failed++;
            $display("FAIL fill_step%0d got full=%b cnt=%0d addr=%0d af=%b", k,
                     wfull, wcount, waddr, walmost_full);
         end
      end
      tests_run++;
      if ({wptr_gray, woverflow} !== {5'b11000, 1'b0}) begin
         tests_failed++;
         $display("FAIL full_gray got gray=%b ovf=%b expected 11000 0", wptr_gray, woverflow);
      end
      step();
      wen = 1'b0;
      tests_run++;
      if ({woverflow, waddr, wcount, wptr_gray, wfull} !== {1'b1, 4'd0, 5'd16, 5'b11000, 1'b1}) begin
         tests_failed++;
         $display("FAIL overflow got ovf=%b addr=%0d cnt=%0d gray=%b full=%b",
                  woverflow, waddr, wcount, wptr_gray, wfull);
      end
   endtask

   task automatic test_drain();
      rptr_gray = 5'b00001;
      step();
      tests_run++;
      if ({wfull, wcount} !== {1'b1, 5'd16}) begin
         tests_failed++;
         $display("FAIL drain_edge1 got full=%b cnt=%0d expected 1 16", wfull, wcount);
      end
      step();
      tests_run++;
      if ({wfull, wcount, waddr} !== {1'b0, 5'd15, 4'd0}) begin
         tests_failed++;
         $display("FAIL drain_edge2 got full=%b cnt=%0d addr=%0d expected 0 15 0", wfull, wcount, waddr);
      end
      wen = 1'b1;
      step();
      wen = 1'b0;
      tests_run++;
      if ({wfull, wcount, waddr, wptr_gray} !== {1'b1, 5'd16, 4'd1, 5'b11001}) begin
         tests_failed++;
         $display("FAIL drain_refill got full=%b cnt=%0d addr=%0d gray=%b expected 1 16 1 11001",
                  wfull, wcount, waddr, wptr_gray);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      wen = 1'b1;
      repeat (16) step();
      rptr_gray = 5'b00001;
      step();
      wen = 1'b0;
      tests_run++;
      if ({woverflow, wfull, wcount, waddr, wptr_gray} !== {1'b1, 1'b1, 5'd16, 4'd0, 5'b11000}) begin
         tests_failed++;
         $display("FAIL simul_reject got ovf=%b full=%b cnt=%0d addr=%0d gray=%b",
                  woverflow, wfull, wcount, waddr, wptr_gray);
      end
      step();
      tests_run++;
      if ({wfull, wcount, woverflow} !== {1'b0, 5'd15, 1'b1}) begin
         tests_failed++;
         $display("FAIL simul_release got full=%b cnt=%0d ovf=%b expected 0 15 1", wfull, wcount, woverflow);
      end
   endtask

   task automatic test_reset_midburst();
      do_reset();
      wen = 1'b1;
      repeat (7) step();
      wen = 1'b0;
      tests_run++;
      if (wcount !== 5'd7) begin
         tests_failed++;
         $display("FAIL midburst_count got %0d expected 7", wcount);
      end
      #2 wrst_n = 1'b0;
      #1;
      tests_run++;
      if ({waddr, wptr_gray, wfull, walmost_full, woverflow, wcount} !== 17'b0) begin
         tests_failed++;
         $display("FAIL midburst_reset got %b expected all zero",
                  {waddr, wptr_gray, wfull, walmost_full, woverflow, wcount});
      end
      wrst_n = 1'b1;
      step();
      tests_run++;
      if ({waddr, wptr_gray, wcount} !== 14'b0) begin
         tests_failed++;
         $display("FAIL midburst_after got addr=%0d gray=%b cnt=%0d expected 0", waddr, wptr_gray, wcount);
      end
   endtask

   task automatic test_wrap();
      logic [4:0] prev;
      do_reset();
      prev = 5'b0;
      wen = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         tests_run++;
         if ({waddr, wptr_gray, wfull, wcount} !== {4'(k), g5(k), 1'b0, 5'((k >= 6) ? 6 : k)}) begin
            tests_failed++;
            $display("FAIL wrap_step%0d got addr=%0d gray=%b full=%b cnt=%0d", k,
                     waddr, wptr_gray, wfull, wcount);
         end
         tests_run++;
         if ($countones(prev ^ wptr_gray) != 1) begin
            tests_failed++;
            $display("FAIL wrap_onebit%0d got %b -> %b", k, prev, wptr_gray);
         end
         prev = wptr_gray;
         rptr_gray = g5((k >= 4) ? (k - 4) : 0);
      end
      wen = 1'b0;
   endtask

   task automatic test_idle();
      repeat (3) step();
      tests_run++;
      if ({waddr, wptr_gray, wcount, wfull} !== {4'd8, 5'b01100, 5'd4, 1'b0}) begin
         tests_failed++;
         $display("FAIL idle_hold got addr=%0d gray=%b cnt=%0d full=%b expected 8 01100 4 0",
                  waddr, wptr_gray, wcount, wfull);
      end
   endtask

   task automatic test_almost_full();
      do_reset();
      wen = 1'b1;
      repeat (11) step();
      tests_run++;
      if ({wcount, walmost_full} !== {5'd11, 1'b0}) begin
         tests_failed++;
         $display("FAIL af_11 got cnt=%0d af=%b expected 11 0", wcount, walmost_full);
      end
      step();
      wen = 1'b0;
      tests_run++;
      if ({wcount, walmost_full} !== {5'd12, AF_EN}) begin
         tests_failed++;
         $display("FAIL af_12 got cnt=%0d af=%b expected 12 %b", wcount, walmost_full, AF_EN);
      end
   endtask

   initial begin
      test_reset();
      test_fill_full();
      test_drain();
      test_simultaneous();
      test_reset_midburst();
      test_wrap();
      test_idle();
      test_almost_full();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
